// File: rtl/uframe_master.sv
// uframe_master: initiator side of the UART frame protocol.
// Serialises a local read/write command into a 14-byte frame and parses the
// read-reply frame (header "ABCDEF", then 4 address and 4 data bytes, LSB first).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready_o high unless a done pulse is out
// SEND   | pacing the 14 frame bytes out to the UART tx core
// WAIT   | read issued; rx parser armed, reply timeout running
module uframe_master #(
  parameter int unsigned CLK_RATE = 50000000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        tx_en_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  input  logic        rx_en_i,
  input  logic [7:0]  rx_data_i,
  output logic        wr_done_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;

  localparam logic [31:0] TO_LAST = 32'(CLK_RATE - 1);
  localparam logic [47:0] HDR     = 48'h41_42_43_44_45_46;

  state_e      state_q, state_d;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  idx_q;
  logic [2:0]  guard_q;
  logic [31:0] tcnt_q;
  logic [39:0] win_q;
  logic        hdr_q;
  logic [2:0]  cap_cnt_q;
  logic [55:0] cap_q;

  logic        tx_en_q;
  logic [7:0]  tx_data_q;
  logic        wr_done_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        rsp_timeout_q;

  logic        accept;
  logic        issue;
  logic        last_byte;
  logic [47:0] win_next;
  logic        in_wait;
  logic        rsp_done;
  logic        timeout;
  logic [7:0]  byte_d;

  assign accept    = cmd_valid_i && cmd_ready_o;
  // Guard reaching 7 with tx_ready still high means 8 consecutive idle cycles seen.
  assign issue     = (state_q == S_SEND) && (guard_q == 3'd7) && tx_ready_i;
  assign last_byte = issue && (idx_q == 4'd13);
  assign in_wait   = (state_q == S_WAIT);
  assign win_next  = {win_q, rx_data_i};
  assign rsp_done  = in_wait && rx_en_i && hdr_q && (cap_cnt_q == 3'd7);
  // A completing reply in the same cycle takes priority over the timeout.
  assign timeout   = in_wait && (tcnt_q == TO_LAST) && !rsp_done;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_SEND;
      S_SEND: if (last_byte) state_d = wr_q ? S_IDLE : S_WAIT;
      S_WAIT: if (rsp_done || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ready stays low through the completion pulse cycle
  always_comb begin
    cmd_ready_o = (state_q == S_IDLE) && !wr_done_q && !rsp_valid_q;
  end

  // Frame byte selected by the current index
  always_comb begin
    byte_d = 8'h00;
    case (idx_q)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5:
        byte_d = wr_q ? (8'h41 + {4'd0, idx_q}) : (8'h46 - {4'd0, idx_q});
      4'd6:  byte_d = addr_q[7:0];
      4'd7:  byte_d = addr_q[15:8];
      4'd8:  byte_d = addr_q[23:16];
      4'd9:  byte_d = addr_q[31:24];
      4'd10: byte_d = wr_q ? wdata_q[7:0]   : 8'h00;
      4'd11: byte_d = wr_q ? wdata_q[15:8]  : 8'h00;
      4'd12: byte_d = wr_q ? wdata_q[23:16] : 8'h00;
      4'd13: byte_d = wr_q ? wdata_q[31:24] : 8'h00;
      default: byte_d = 8'h00;
    endcase
  end

  // Command latch, byte index and tx guard counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      guard_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= cmd_write_i;
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
        idx_q   <= '0;
      end else if (issue) begin
        idx_q <= idx_q + 4'd1;
      end
      if ((state_q != S_SEND) || tx_en_q || !tx_ready_i) guard_q <= '0;
      else                                                guard_q <= guard_q + 3'd1;
    end
  end

  // Reply timeout counter and rx parser; both idle outside WAIT
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tcnt_q    <= '0;
      win_q     <= '0;
      hdr_q     <= 1'b0;
      cap_cnt_q <= '0;
      cap_q     <= '0;
    end else if (!in_wait || rsp_done || timeout) begin
      tcnt_q    <= '0;
      win_q     <= '0;
      hdr_q     <= 1'b0;
      cap_cnt_q <= '0;
    end else if (rx_en_i) begin
      tcnt_q <= '0;
      if (hdr_q) begin
        cap_q     <= {rx_data_i, cap_q[55:8]};
        cap_cnt_q <= cap_cnt_q + 3'd1;
      end else begin
        win_q <= win_next[39:0];
        if (win_next == HDR) hdr_q <= 1'b1;
      end
    end else begin
      tcnt_q <= tcnt_q + 32'd1;
    end
  end

  // Registered outputs toward UART tx and the command source
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_en_q       <= 1'b0;
      tx_data_q     <= '0;
      wr_done_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      tx_en_q     <= issue;
      wr_done_q   <= last_byte && wr_q;
      rsp_valid_q <= rsp_done || timeout;
      if (issue) tx_data_q <= byte_d;
      if (rsp_done) begin
        rsp_data_q    <= {rx_data_i, cap_q[55:32]};
        rsp_err_q     <= (cap_q[31:0] != addr_q);
        rsp_timeout_q <= 1'b0;
      end else if (timeout) begin
        rsp_data_q    <= '0;
        rsp_err_q     <= 1'b0;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign tx_en_o       = tx_en_q;
  assign tx_data_o     = tx_data_q;
  assign wr_done_o     = wr_done_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_uframe_master.sv
// Testbench for uframe_master: randomized commands and replies checked against
// a cycle-level model of the frame contents, byte pacing and reply handling.
module tb_uframe_master;

  localparam int CLK_RATE = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        tx_en, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_en;
  logic [7:0]  rx_data;
  logic        wr_done, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_data;

  uframe_master #(.CLK_RATE(CLK_RATE)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .tx_en_o(tx_en), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .rx_en_i(rx_en), .rx_data_i(rx_data),
    .wr_done_o(wr_done), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model / monitor state
  int cyc = 0, run = 0, busy = 0, busy_max = 0, nbytes = 0;
  int pace_err = 0, ready_err = 0, stray = 0;
  int rsp_cnt = 0, rsp_cyc = 0, last_tx_cyc = 0, rx_cyc = 0;
  bit frame_active = 0, dut_busy = 0, stall = 0;
  logic [31:0] rsp_d;
  logic        rsp_e, rsp_t;
  logic [7:0]  tx_q[$];
  logic        wd_q[$];
  logic [7:0]  exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // Expected frame from the protocol rules
  function automatic void build_exp(input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(w ? 8'(8'h41 + i) : 8'(8'h46 - i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(a >> (8 * i)));
    for (int i = 0; i < 4; i++) exp_q.push_back(w ? 8'(d >> (8 * i)) : 8'h00);
  endfunction

  // One clock: observe outputs, run the tx pacing model, drive the UART tx model.
  // tx_en is due exactly when the 8 preceding cycles since the last byte/accept had tx_ready high.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (tx_en !== (frame_active && run >= 8)) pace_err++;
    if (dut_busy && cmd_ready === 1'b1) ready_err++;
    if (tx_en === 1'b1) begin
      tx_q.push_back(tx_data);
      wd_q.push_back(wr_done);
      last_tx_cyc = cyc;
      if (frame_active) begin
        nbytes++;
        if (nbytes == 14) frame_active = 0;
      end
      busy = (busy_max == 0) ? 0 : int'($urandom_range(busy_max, 0));
    end else if (wr_done === 1'b1) stray++;
    if (rsp_valid === 1'b1) begin
      rsp_cnt++; rsp_cyc = cyc; rsp_d = rsp_data; rsp_e = rsp_err; rsp_t = rsp_timeout;
      dut_busy = 0;
    end
    if (wr_done === 1'b1) dut_busy = 0;
    if (busy > 0) begin tx_ready = 1'b0; busy--; end
    else tx_ready = !stall;
    if (tx_en === 1'b1) run = 0;
    else run = tx_ready ? run + 1 : 0;
  endtask

  task automatic start_cmd(input bit w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    frame_active = 1; nbytes = 0; run = 0; dut_busy = 1;
    tx_q.delete(); wd_q.delete();
    pace_err = 0; ready_err = 0; stray = 0;
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_frame(output bit ok);
    int n = 0;
    while (frame_active && n < 3000) begin tick(); n++; end
    ok = !frame_active;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_en = 1; rx_data = b; rx_cyc = cyc;
    tick();
    rx_en = 0;
  endtask

  task automatic gap(input bit en);
    if (en) repeat ($urandom_range(2, 0)) tick();
  endtask

  task automatic feed_reply(input logic [31:0] ra, input logic [31:0] d, input int junk,
                            input bit aa, input bit gaps);
    for (int i = 0; i < junk; i++) begin send_rx(8'($urandom_range(63, 0))); gap(gaps); end
    if (aa) begin send_rx(8'h41); send_rx(8'h41); end
    for (int i = 0; i < 6; i++) begin send_rx(8'(8'h41 + i)); gap(gaps); end
    for (int i = 0; i < 4; i++) begin send_rx(8'(ra >> (8 * i))); gap(gaps); end
    for (int i = 0; i < 4; i++) begin
      send_rx(8'(d >> (8 * i)));
      if (i < 3) gap(gaps);
    end
  endtask

  task automatic wait_rsp(input int start_cnt, input int limit, output bit ok);
    int n = 0;
    while (rsp_cnt == start_cnt && n < limit) begin tick(); n++; end
    ok = (rsp_cnt != start_cnt);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    tests++; if (tx_en !== 1'b0) begin fails++; $display("FAIL reset_tx_en got %b want 0", tx_en); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    tests++; if ({wr_done, rsp_valid, rsp_err, rsp_timeout} !== 4'b0) begin
      fails++; $display("FAIL reset_pulses got %b want 0000", {wr_done, rsp_valid, rsp_err, rsp_timeout}); end
    tests++; if (rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
  endtask

  task automatic test_write(input logic [31:0] a, input logic [31:0] d, input int bmax, input bit stall_mid);
    bit ok;
    int wcnt = 0;
    int n = 0;
    busy_max = bmax;
    build_exp(1, a, d);
    start_cmd(1, a, d);
    cmd_valid = 1; cmd_write = 0; cmd_addr = ~a; cmd_wdata = ~d;
    if (stall_mid) begin
      while (nbytes < 5 && n < 1000) begin tick(); n++; end
      stall = 1;
      repeat (50) tick();
      stall = 0;
    end
    wait_frame(ok);
    cmd_valid = 0;
    tests++; if (!ok) begin fails++; $display("FAIL wr_frame_done got %0d bytes want 14", nbytes); end
    tests++; if (tx_q.size() != 14) begin fails++; $display("FAIL wr_byte_count got %0d want 14", tx_q.size()); end
    for (int i = 0; i < 14 && i < tx_q.size(); i++) begin
      tests++;
      if (tx_q[i] !== exp_q[i]) begin fails++; $display("FAIL wr_byte[%0d] got %h want %h", i, tx_q[i], exp_q[i]); end
    end
    foreach (wd_q[i]) if (wd_q[i] === 1'b1) wcnt++;
    tests++; if (wcnt != 1 || wd_q.size() != 14 || wd_q[13] !== 1'b1 || stray != 0) begin
      fails++; $display("FAIL wr_done_pulse got count %0d stray %0d want one on byte 14", wcnt, stray); end
    tests++; if (pace_err != 0) begin fails++; $display("FAIL wr_pacing got %0d errors want 0", pace_err); end
    tick();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL wr_ready_back got %b want 1", cmd_ready); end
    tests++; if (ready_err != 0) begin fails++; $display("FAIL wr_ready_busy got %0d high cycles want 0", ready_err); end
  endtask

  task automatic run_read(input logic [31:0] a, input logic [31:0] ra, input logic [31:0] d,
                          input int junk, input bit aa, output bit ok);
    bit fok;
    int c0;
    build_exp(0, a, 32'h0);
    start_cmd(0, a, 32'h0);
    wait_frame(fok);
    c0 = rsp_cnt;
    feed_reply(ra, d, junk, aa, 1);
    wait_rsp(c0, 20, ok);
    ok = ok && fok;
  endtask

  task automatic test_read(input logic [31:0] a, input logic [31:0] ra, input logic [31:0] d,
                           input int junk, input bit aa);
    bit ok;
    int c0;
    busy_max = int'($urandom_range(6, 0));
    c0 = rsp_cnt;
    run_read(a, ra, d, junk, aa, ok);
    tests++; if (!ok || rsp_cnt != c0 + 1) begin fails++; $display("FAIL rd_rsp_seen got %0d responses want 1", rsp_cnt - c0); end
    for (int i = 0; i < 14 && i < tx_q.size(); i++) begin
      tests++;
      if (tx_q[i] !== exp_q[i]) begin fails++; $display("FAIL rd_byte[%0d] got %h want %h", i, tx_q[i], exp_q[i]); end
    end
    tests++; if (tx_q.size() != 14 || stray != 0 || wd_q.sum() with (int'(item)) != 0) begin
      fails++; $display("FAIL rd_frame_shape got %0d bytes stray %0d want 14 and no wr_done", tx_q.size(), stray); end
    tests++; if (rsp_cyc != rx_cyc + 1) begin fails++; $display("FAIL rd_latency got %0d want 1", rsp_cyc - rx_cyc); end
    tests++; if (rsp_d !== d) begin fails++; $display("FAIL rd_data got %h want %h", rsp_d, d); end
    tests++; if (rsp_e !== (ra != a)) begin fails++; $display("FAIL rd_err got %b want %b", rsp_e, ra != a); end
    tests++; if (rsp_t !== 1'b0) begin fails++; $display("FAIL rd_timeout got %b want 0", rsp_t); end
    tests++; if (pace_err != 0 || ready_err != 0) begin
      fails++; $display("FAIL rd_pacing got %0d/%0d errors want 0/0", pace_err, ready_err); end
    repeat (4) tick();
    tests++; if (rsp_data !== d || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL rd_hold got %h valid %b want %h valid 0", rsp_data, rsp_valid, d); end
  endtask

  task automatic test_timeout();
    bit fok, ok;
    int c0;
    logic [31:0] a;
    a = $urandom;
    busy_max = 0;
    c0 = rsp_cnt;
    feed_reply(a, 32'h1234_5678, 0, 0, 0);
    tick();
    tests++; if (rsp_cnt != c0) begin fails++; $display("FAIL to_idle_rx got %0d responses want 0", rsp_cnt - c0); end
    build_exp(0, a, 32'h0);
    start_cmd(0, a, 32'h0);
    feed_reply(a, 32'h1234_5678, 0, 0, 0);
    wait_frame(fok);
    wait_rsp(c0, 1200, ok);
    tests++; if (!ok || !fok) begin fails++; $display("FAIL to_rsp_seen got none want timeout response"); end
    tests++; if (rsp_cyc - last_tx_cyc != CLK_RATE) begin
      fails++; $display("FAIL to_latency got %0d want %0d", rsp_cyc - last_tx_cyc, CLK_RATE); end
    tests++; if ({rsp_t, rsp_e} !== 2'b10 || rsp_d !== 32'h0) begin
      fails++; $display("FAIL to_flags got to=%b err=%b data=%h want to=1 err=0 data=0", rsp_t, rsp_e, rsp_d); end
    tests++; if (tx_q.size() != 14 || tx_q[13] !== exp_q[13] || tx_q[0] !== exp_q[0]) begin
      fails++; $display("FAIL to_frame got %0d bytes want 14 read bytes", tx_q.size()); end
    tick();
    tests++; if (rsp_cnt != c0 + 1 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL to_single got %0d responses ready %b want 1 ready 1", rsp_cnt - c0, cmd_ready); end
  endtask

  task automatic test_tie();
    bit fok, ok;
    int c0, r;
    logic [31:0] a, d;
    a = $urandom; d = $urandom;
    busy_max = 2;
    start_cmd(0, a, 32'h0);
    wait_frame(fok);
    c0 = rsp_cnt;
    for (int i = 0; i < 6; i++) send_rx(8'(8'h41 + i));
    for (int i = 0; i < 4; i++) send_rx(8'(a >> (8 * i)));
    for (int i = 0; i < 3; i++) send_rx(8'(d >> (8 * i)));
    r = rx_cyc;
    while (cyc < r + CLK_RATE && rsp_cnt == c0) tick();
    send_rx(8'(d >> 24));
    wait_rsp(c0, 5, ok);
    tests++; if (!ok || !fok || rsp_cnt != c0 + 1) begin
      fails++; $display("FAIL tie_rsp got %0d responses want 1", rsp_cnt - c0); end
    tests++; if (rsp_t !== 1'b0 || rsp_d !== d || rsp_e !== 1'b0 || rsp_cyc != r + CLK_RATE + 1) begin
      fails++; $display("FAIL tie_reply_wins got to=%b data=%h at +%0d want to=0 data=%h at +%0d",
                        rsp_t, rsp_d, rsp_cyc - r, d, CLK_RATE + 1); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int c0;
    busy_max = 3;
    start_cmd(1, $urandom, $urandom);
    while (nbytes < 4 && n < 1000) begin tick(); n++; end
    rst_n = 0;
    #1;
    frame_active = 0; dut_busy = 0; busy = 0; pace_err = 0; stray = 0;
    c0 = rsp_cnt;
    tests++; if ({cmd_ready, tx_en, tx_data, wr_done, rsp_valid, rsp_data, rsp_err, rsp_timeout} !==
                 {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL midrst_outputs got ready=%b tx_en=%b data=%h wr=%b rv=%b want reset values",
                        cmd_ready, tx_en, tx_data, wr_done, rsp_valid); end
    repeat (3) tick();
    rst_n = 1;
    repeat (30) tick();
    tests++; if (pace_err != 0 || stray != 0 || rsp_cnt != c0) begin
      fails++; $display("FAIL midrst_quiet got tx %0d wr %0d rsp %0d want 0", pace_err, stray, rsp_cnt - c0); end
    test_write($urandom, $urandom, 4, 0);
  endtask

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    tx_ready = 1; rx_en = 0; rx_data = '0;
    test_reset();
    test_write(32'h1234_5678, 32'hA5A5_0F0F, 3, 0);
    for (int i = 0; i < 3; i++) test_write($urandom, $urandom, (i == 0) ? 0 : 10, 0);
    test_read(32'h0000_0010, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);
    test_read(32'h0000_0010, 32'h0000_0014, $urandom, 0, 1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = $urandom;
      test_read(a, ($urandom_range(1, 0) == 1) ? a : a ^ (32'h1 << $urandom_range(31, 0)),
                $urandom, int'($urandom_range(4, 0)), 1'($urandom_range(1, 0)));
    end
    test_timeout();
    test_tie();
    test_write($urandom, $urandom, 2, 1);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
